mem_access_stage: RTL and testbench

- Pipeline stage directly downstream of Execute: consumes ALU result, store data and control for one instruction at a time.
- Performs loads and stores against the data memory over a req/gnt/rvalid handshake, formats load data, and presents a registered writeback bundle to WB.
- Drives the MEM-side forwarding bundle back into Execute's forwarding unit.
- Stalls upstream by deasserting ex_ready while a memory access is outstanding.

---
 rtl/mem_access_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: ALU passthrough, data-memory loads/stores, MEM forwarding bundle.
// Optional macro MEM_MISALIGN_CHECK_EN enables alignment checking of H/W accesses.
module mem_access_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [REG_AW-1:0] fwd_rd,
  output logic              fwd_reg_write,
  output logic [XLEN-1:0]   fwd_alu_result,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_reg_write,
  output logic [XLEN-1:0]   wb_data,
  output logic              misalign_err
);

  localparam int unsigned BE_W = 4;
  localparam int unsigned F3_W = 3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} stateT;

  stateT             state, stateNext;
  logic              exReadyNext, dmemReqNext, dmemWeNext;
  logic [XLEN-1:0]   dmemAddrNext, dmemWdataNext;
  logic [BE_W-1:0]   dmemBeNext;
  logic [REG_AW-1:0] fwdRdNext, wbRdNext;
  logic              fwdRegWriteNext, wbValidNext, wbRegWriteNext, misalignErrNext;
  logic [XLEN-1:0]   fwdAluResultNext, wbDataNext;
  logic              heldRegWrite, heldRegWriteNext;
  logic [F3_W-1:0]   heldFunct3, heldFunct3Next;

  logic              exMemOp, exMisaligned;
  logic [1:0]        exOffset;
  logic [BE_W-1:0]   beBase, exBe;
  logic [XLEN-1:0]   exWdata;

  assign exMemOp  = ex_mem_read | ex_mem_write;
  assign exOffset = ex_alu_result[1:0];
  // Shifting a 4-bit mask drops enables that fall past byte 3.
  assign exBe     = beBase << exOffset;

  // Byte-lane mask and lane-positioned store data.
  always_comb begin
    beBase  = 4'b1111;
    exWdata = ex_store_data << {exOffset, 3'b000};
    case (ex_funct3[1:0])
      2'b00: begin
        beBase  = 4'b0001;
        exWdata = XLEN'({4{ex_store_data[7:0]}});
      end
      2'b01: begin
        beBase  = 4'b0011;
        exWdata = XLEN'({2{ex_store_data[15:0]}}) << {exOffset[0], 3'b000};
      end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    case (ex_funct3[1:0])
      2'b00:   exMisaligned = 1'b0;
      2'b01:   exMisaligned = exOffset[0];
      default: exMisaligned = |exOffset;
    endcase
  end
`else
  assign exMisaligned = 1'b0;
`endif

  // Lane select and sign/zero extension of the returned load word.
  function automatic logic [XLEN-1:0] formatLoad(input logic [XLEN-1:0] rdata,
                                                 input logic [1:0] offset,
                                                 input logic [F3_W-1:0] funct3);
    logic [XLEN-1:0] shifted;
    shifted = rdata >> {offset, 3'b000};
    case (funct3[1:0])
      2'b00:   formatLoad = funct3[2] ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                      : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'b01:   formatLoad = funct3[2] ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                      : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      default: formatLoad = shifted;
    endcase
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    stateNext        = state;
    dmemReqNext      = dmem_req;
    dmemWeNext       = dmem_we;
    dmemAddrNext     = dmem_addr;
    dmemWdataNext    = dmem_wdata;
    dmemBeNext       = dmem_be;
    fwdRdNext        = fwd_rd;
    fwdRegWriteNext  = fwd_reg_write;
    fwdAluResultNext = fwd_alu_result;
    heldRegWriteNext = heldRegWrite;
    heldFunct3Next   = heldFunct3;
    wbValidNext      = 1'b0;
    wbRdNext         = wb_rd;
    wbRegWriteNext   = wb_reg_write;
    wbDataNext       = wb_data;
    misalignErrNext  = 1'b0;

    case (state)
      IDLE: begin
        if (ex_valid && ex_ready) begin
          fwdRdNext        = ex_rd;
          fwdRegWriteNext  = ex_reg_write && !ex_mem_read;
          fwdAluResultNext = ex_alu_result;
          heldRegWriteNext = ex_reg_write;
          heldFunct3Next   = ex_funct3;
          if (exMemOp && exMisaligned) begin
            misalignErrNext = 1'b1;
            wbValidNext     = 1'b1;
            wbRegWriteNext  = 1'b0;
            wbRdNext        = '0;
            wbDataNext      = ex_alu_result;
          end else if (exMemOp) begin
            stateNext     = REQ;
            dmemReqNext   = 1'b1;
            dmemWeNext    = ex_mem_write;
            dmemAddrNext  = {ex_alu_result[XLEN-1:2], 2'b00};
            dmemBeNext    = exBe;
            dmemWdataNext = exWdata;
          end else begin
            wbValidNext    = 1'b1;
            wbRegWriteNext = ex_reg_write;
            wbRdNext       = ex_reg_write ? ex_rd : '0;
            wbDataNext     = ex_alu_result;
          end
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          dmemReqNext = 1'b0;
          if (dmem_we) begin
            stateNext      = IDLE;
            wbValidNext    = 1'b1;
            wbRegWriteNext = 1'b0;
            wbRdNext       = '0;
            wbDataNext     = fwd_alu_result;
          end else begin
            stateNext = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (dmem_rvalid) begin
          stateNext      = IDLE;
          wbValidNext    = 1'b1;
          wbRegWriteNext = heldRegWrite;
          wbRdNext       = heldRegWrite ? fwd_rd : '0;
          wbDataNext     = formatLoad(dmem_rdata, fwd_alu_result[1:0], heldFunct3);
        end
      end
      default: stateNext = IDLE;
    endcase

    exReadyNext = (stateNext == IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ex_ready       <= 1'b1;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_be        <= '0;
      fwd_rd         <= '0;
      fwd_reg_write  <= 1'b0;
      fwd_alu_result <= '0;
      heldRegWrite   <= 1'b0;
      heldFunct3     <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_reg_write   <= 1'b0;
      wb_data        <= '0;
      misalign_err   <= 1'b0;
    end else begin
      state          <= stateNext;
      ex_ready       <= exReadyNext;
      dmem_req       <= dmemReqNext;
      dmem_we        <= dmemWeNext;
      dmem_addr      <= dmemAddrNext;
      dmem_wdata     <= dmemWdataNext;
      dmem_be        <= dmemBeNext;
      fwd_rd         <= fwdRdNext;
      fwd_reg_write  <= fwdRegWriteNext;
      fwd_alu_result <= fwdAluResultNext;
      heldRegWrite   <= heldRegWriteNext;
      heldFunct3     <= heldFunct3Next;
      wb_valid       <= wbValidNext;
      wb_rd          <= wbRdNext;
      wb_reg_write   <= wbRegWriteNext;
      wb_data        <= wbDataNext;
      misalign_err   <= misalignErrNext;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed stimulus pushes expected writebacks,
// a negedge monitor pops and compares them whenever wb_valid is seen.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  fwd_rd;
  logic        fwd_reg_write;
  logic [31:0] fwd_alu_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        misalign_err;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .fwd_rd(fwd_rd), .fwd_reg_write(fwd_reg_write), .fwd_alu_result(fwd_alu_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        chkData;
  } wbExpT;

  wbExpT expQ[$];
  int checks = 0;
  int errors = 0;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [4:0] rd, input logic we, input logic [31:0] data,
                         input logic chkData);
    wbExpT e;
    e.rd = rd; e.we = we; e.data = data; e.chkData = chkData;
    expQ.push_back(e);
  endtask

  // Writeback monitor
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got rd=%0d we=%0b data=0x%08h, expected no writeback",
                 wb_rd, wb_reg_write, wb_data);
      end else begin
        wbExpT e;
        e = expQ.pop_front();
        if (wb_rd !== e.rd || wb_reg_write !== e.we || (e.chkData && wb_data !== e.data)) begin
          errors++;
          $display("FAIL wb: got rd=%0d we=%0b data=0x%08h, expected rd=%0d we=%0b data=0x%08h",
                   wb_rd, wb_reg_write, wb_data, e.rd, e.we, e.data);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
    ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3;
  endtask

  task automatic aluOp(input logic [4:0] rd, input logic rw, input logic [31:0] res);
    @(negedge clk);
    chk("alu_ex_ready", 32'(ex_ready), 32'd1);
    issue(res, 32'h0, rd, rw, 1'b0, 1'b0, F_W);
    pushExp(rw ? rd : 5'd0, rw, res, 1'b1);
  endtask

  task automatic storeOp(input logic [31:0] addr, input logic [31:0] sd, input logic [2:0] f3,
                         input logic [3:0] expBe, input logic [31:0] expWdata, input int waitCycles);
    @(negedge clk);
    chk("st_ex_ready_idle", 32'(ex_ready), 32'd1);
    issue(addr, sd, 5'd0, 1'b0, 1'b0, 1'b1, f3);
    pushExp(5'd0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i <= waitCycles; i++) begin
      @(negedge clk);
      ex_valid = 1'b0;
      chk("st_req", 32'(dmem_req), 32'd1);
      chk("st_we", 32'(dmem_we), 32'd1);
      chk("st_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      chk("st_be", 32'(dmem_be), 32'(expBe));
      chk("st_wdata", dmem_wdata, expWdata);
      chk("st_ex_ready_busy", 32'(ex_ready), 32'd0);
      if (i == waitCycles) dmem_gnt = 1'b1;
    end
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("st_req_drop", 32'(dmem_req), 32'd0);
    chk("st_ex_ready_done", 32'(ex_ready), 32'd1);
  endtask

  task automatic loadOp(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] rdata, input logic [31:0] expData);
    @(negedge clk);
    chk("ld_ex_ready_idle", 32'(ex_ready), 32'd1);
    issue(addr, 32'h0, rd, 1'b1, 1'b1, 1'b0, f3);
    pushExp(rd, 1'b1, expData, 1'b1);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("ld_req", 32'(dmem_req), 32'd1);
    chk("ld_we", 32'(dmem_we), 32'd0);
    chk("ld_addr", dmem_addr, addr & 32'hFFFF_FFFC);
    chk("ld_fwd_rd", 32'(fwd_rd), 32'(rd));
    chk("ld_fwd_reg_write", 32'(fwd_reg_write), 32'd0);
    chk("ld_ex_ready_busy", 32'(ex_ready), 32'd0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("ld_req_drop", 32'(dmem_req), 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("ld_ex_ready_done", 32'(ex_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_rd = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

    @(negedge clk);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_fwd_reg_write", 32'(fwd_reg_write), 32'd0);
    rst = 1'b0;

    // Back-to-back ALU ops, then x0 write and a non-writing op
    aluOp(5'd1, 1'b1, 32'd5);
    aluOp(5'd2, 1'b1, 32'd6);
    aluOp(5'd3, 1'b1, 32'd7);
    aluOp(5'd0, 1'b1, 32'h55);
    aluOp(5'd9, 1'b0, 32'h66);
    @(negedge clk);
    ex_valid = 1'b0;

    // Stores
    storeOp(32'h103, 32'h0000_00AB, F_B, 4'b1000, 32'hABAB_ABAB, 2);
    storeOp(32'h102, 32'h1234_BEEF, F_H, 4'b1100, 32'hBEEF_BEEF, 0);
    storeOp(32'h104, 32'hCAFE_F00D, F_W, 4'b1111, 32'hCAFE_F00D, 1);

    // Loads
    loadOp(32'h102, F_B,  5'd4, 32'h0080_FF00, 32'hFFFF_FF80);
    loadOp(32'h102, F_BU, 5'd4, 32'h0080_FF00, 32'h0000_0080);
    loadOp(32'h102, F_H,  5'd8, 32'h8001_0000, 32'hFFFF_8001);
    loadOp(32'h102, F_HU, 5'd8, 32'h8001_0000, 32'h0000_8001);
    loadOp(32'h100, F_W,  5'd10, 32'h1234_5678, 32'h1234_5678);

`ifdef MEM_MISALIGN_CHECK_EN
    // Misaligned LH: no request, error pulse, non-writing writeback
    @(negedge clk);
    issue(32'h101, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, F_H);
    pushExp(5'd0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_ex_ready", 32'(ex_ready), 32'd1);
    @(negedge clk);
    chk("mis_err_pulse", 32'(misalign_err), 32'd0);
    chk("mis_req_after", 32'(dmem_req), 32'd0);
`else
    // Unchecked LH at odd address reads in-word bytes 2:1
    loadOp(32'h101, F_H, 5'd11, 32'h00AB_CD00, 32'hFFFF_ABCD);
    chk("nochk_misalign", 32'(misalign_err), 32'd0);
`endif

    // Reset while in REQ drops dmem_req asynchronously
    @(negedge clk);
    issue(32'h400, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, F_W);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rreq_req", 32'(dmem_req), 32'd1);
    #1 rst = 1'b1;
    #1 chk("rreq_async_drop", 32'(dmem_req), 32'd0);
    chk("rreq_ex_ready", 32'(ex_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Reset while in WAIT_RD; late rvalid/gnt must be ignored
    @(negedge clk);
    issue(32'h200, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, F_W);
    @(negedge clk);
    ex_valid = 1'b0;
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("rwait_req", 32'(dmem_req), 32'd0);
    rst = 1'b1;
    #1 chk("rwait_ex_ready", 32'(ex_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dmem_rvalid = 1'b1;
    dmem_gnt    = 1'b1;
    dmem_rdata  = 32'h1111_1111;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    dmem_gnt    = 1'b0;
    chk("rwait_idle_ready", 32'(ex_ready), 32'd1);
    chk("rwait_idle_req", 32'(dmem_req), 32'd0);
    chk("rwait_no_wb", 32'(wb_valid), 32'd0);

    // Forwarding: ALU op held, then a load to the same rd
    aluOp(5'd7, 1'b1, 32'h10);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("fwd_rd", 32'(fwd_rd), 32'd7);
    chk("fwd_reg_write", 32'(fwd_reg_write), 32'd1);
    chk("fwd_alu_result", fwd_alu_result, 32'h10);
    loadOp(32'h300, F_W, 5'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
